// File: rtl/ascon_permutation_core.sv
// Iterative Ascon-p[rnd] engine: UNROLL rounds per cycle on a single state register.
// Latency ceil(min(rnd,16)/UNROLL) cycles after accept; output held in DONE until ready_i.
package ascon_pkg;
  typedef logic [4:0][63:0] ascon_state_t;
endpackage

module ascon_permutation_core #(
  parameter int UNROLL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  ascon_pkg::ascon_state_t state_i,
  input  logic [4:0]              rounds_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output ascon_pkg::ascon_state_t state_o,
  output logic                    busy_o
);
  import ascon_pkg::*;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  ascon_state_t state_q;
  ascon_state_t run_state;
  logic [4:0]   remaining_q;
  logic [3:0]   rc_idx_q;
  logic [4:0]   rounds_clamped;
  logic [4:0]   step_n;

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:  c = 8'h3c;
      4'd1:  c = 8'h2d;
      4'd2:  c = 8'h1e;
      4'd3:  c = 8'h0f;
      4'd4:  c = 8'hf0;
      4'd5:  c = 8'he1;
      4'd6:  c = 8'hd2;
      4'd7:  c = 8'hc3;
      4'd8:  c = 8'hb4;
      4'd9:  c = 8'ha5;
      4'd10: c = 8'h96;
      4'd11: c = 8'h87;
      4'd12: c = 8'h78;
      4'd13: c = 8'h69;
      4'd14: c = 8'h5a;
      default: c = 8'h4b;
    endcase
    return c;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    ascon_state_t r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, rc};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    r[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    r[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    r[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    r[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return r;
  endfunction

  always_comb begin
    rounds_clamped = (rounds_i > 5'd16) ? 5'd16 : rounds_i;
    step_n = (remaining_q < 5'(UNROLL)) ? remaining_q : 5'(UNROLL);
  end

  // Chain stages past step_n pass their input through unchanged.
  always_comb begin
    ascon_state_t cur;
    cur = state_q;
    for (int k = 0; k < UNROLL; k++) begin
      if (5'(k) < step_n) begin
        cur = ascon_round(cur, round_const(rc_idx_q + 4'(k)));
      end
    end
    run_state = cur;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (valid_i) fsm_d = (rounds_clamped == 5'd0) ? DONE : RUN;
      RUN:  if (remaining_q <= 5'(UNROLL)) fsm_d = DONE;
      DONE: if (ready_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      remaining_q <= '0;
      rc_idx_q    <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: begin
          if (valid_i) begin
            state_q     <= state_i;
            remaining_q <= rounds_clamped;
            rc_idx_q    <= 4'(5'd16 - rounds_clamped);
          end
        end
        RUN: begin
          state_q     <= run_state;
          remaining_q <= remaining_q - step_n;
          rc_idx_q    <= rc_idx_q + 4'(step_n);
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (fsm_q == IDLE);
  assign valid_o = (fsm_q == DONE);
  assign busy_o  = (fsm_q != IDLE);
  assign state_o = state_q;

endmodule

// File: doc/ascon_permutation_core.md
# ascon_permutation_core

Iterative Ascon-p[rnd] permutation engine per NIST SP 800-232. It accepts a 320-bit state and a round count over a valid/ready handshake, then holds the state in a register. Each cycle it applies UNROLL rounds of constant addition → S-box layer → linear diffusion. It returns the permuted state over a second valid/ready handshake. It sits between the mode controllers (AEAD/hash/XOF) and the existing combinational round layers, and is the only clocked owner of the permutation state.

## Interface
- UNROLL, default 1: rounds applied per RUN cycle. Legal values are 1, 2 and 4. Each round instance is combinational constant add → S-box layer → linear diffusion.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  input state/round count valid.
- ready_o  output  1  core can accept an input.
- state_i  input  ascon_pkg::ascon_state_t  input state; word [0] = S0 … [4] = S4.
- rounds_i  input  5  number of rounds rnd. Values above 16 are clamped to 16. 0 means passthrough.
- valid_o  output  1  permuted state available.
- ready_i  input  1  consumer accepts the output.
- state_o  output  ascon_pkg::ascon_state_t  permutation state register.
- busy_o  output  1  high in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - ready_o=1.
  - On valid_i&ready_o: load state_i into the state register, set remaining=min(rounds_i,16) and rc_idx=16−remaining.
  - If remaining=0, go to DONE; otherwise go to RUN.
- **RUN:**
  - ready_o=0. Each edge applies n=min(UNROLL, remaining) rounds in sequence, using rc_idx, rc_idx+1, … rc_idx+n−1.
  - Rounds beyond n in the unrolled chain are bypassed: their output equals their input.
  - rc_idx+=n, remaining−=n.
  - Go to DONE when the pre-update remaining≤UNROLL.
- **Constant addition:** S2[7:0] ^= c[rc_idx], where c[0..15] = 3c,2d,1e,0f,f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b (hex). All other bits are unchanged. rc_idx is 4 bits and never wraps, because rc_idx+remaining=16 always holds.
- **DONE:**
  - valid_o=1, ready_o=0, and the state register is frozen.
  - On valid_o&ready_i, go to IDLE.
- **Overlap:** none. A new input is accepted only in IDLE, so ready_o is 0 in the DONE cycle even while ready_i is high.
- **Output:** state_o is driven directly from the state register. It is meaningful only while valid_o=1 and shows intermediate values during RUN.
- **rounds_i:** sampled only at the accept edge; later changes are ignored.
- **valid_i:** ignored in RUN and DONE. No error signalling.

## Timing
- **Reset:**
  - rst=1 at an edge forces IDLE, zeroes the state register, and clears remaining/rc_idx.
  - After that edge: valid_o=0, busy_o=0, ready_o=1, state_o=0.
  - Reset mid-RUN or in DONE aborts with no valid_o pulse.
  - rst has priority over every handshake in the same cycle.
- **Latency:** with accept at edge e0, valid_o is high in the cycle after edge e_K, where K=ceil(min(rnd,16)/UNROLL). rnd=0 gives K=0, so valid_o is high the cycle after e0.
- **Examples:**
  - UNROLL=1, rnd=12: valid_o high 12 cycles after accept.
  - UNROLL=4, rnd=8: 2 cycles.
  - UNROLL=4, rnd=6: 2 cycles; 4 rounds then 2 rounds.
- **Throughput:** back-to-back with ready_i held high gives one permutation per K+2 cycles: accept edge, K RUN edges, output handshake edge.
- **Output stability:** valid_o, once high, stays high and state_o stays stable until the handshake edge. valid_o is low in the cycle after the handshake.
- **Critical path:** UNROLL × (xor + S-box + diffusion). The register is the only clocked element on the datapath; there are no input or output skid registers.

## Test plan
- **Passthrough:** rnd=0, state_i = S0..S4 = 0x0123456789abcdef × k (k=1..5) → valid_o one cycle after accept; state_o == state_i bit-exact.
- **Hash IV:** rnd=12, UNROLL=1, state_i = {S0=0x0000080100cc0002, S1..S4=0} → valid_o exactly 12 cycles after accept; state_o matches the golden software model of Ascon-p[12]. During RUN, trace rc_idx=4..15 and constants f0..4b.
- **Round-count sweep:** rnd = 1, 6, 8, 12, 16, 20 (20 clamps to 16), random states, UNROLL ∈ {1,2,4}.
  - Results match the golden model.
  - Latencies equal ceil(rnd'/UNROLL), e.g. UNROLL=4, rnd=6 → 2 cycles.
- **Backpressure:** hold ready_i=0 for 7 cycles in DONE.
  - valid_o stays 1, state_o does not change, ready_o stays 0.
  - valid_i pulses during RUN and DONE are ignored.
  - After ready_i=1: IDLE next cycle and ready_o=1.
- **Reset mid-run:** rnd=12; assert rst at RUN edge 5.
  - Next cycle: valid_o=0, busy_o=0, ready_o=1, state_o=0.
  - A fresh accept then completes correctly.
- **Back-to-back:** 3 permutations with valid_i and ready_i tied high, rnd=8, UNROLL=1 → accepts spaced exactly 10 cycles apart; all 3 results correct and in order.
